tcdm_bank_adapter: RTL and testbench

TCDM_BANK_ADAPTER -- requirements
Module: tcdm_bank_adapter

---
 rtl/tcdm_bank_adapter.sv | 191 +++++++++++++++++++
 tb/tb_tcdm_bank_adapter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_adapter.sv
// Purpose: adapts a TCDM interconnect port to one single-port SRAM bank and returns read data in grant order.
// Latency: 1 cycle from read grant to response (bypass); longer only when the response FIFO holds older data.
// Backpressure: reads are granted only against response credit; writes are always granted and produce no response.
//
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   req_i/gnt_o, add_i, wen_i,
//   wdata_i, be_i, ini_add_i             interconnect request side
//   vld_o/rdy_i, rdata_o, ini_add_o      interconnect read-response side
//   mem_req_o, mem_add_o, mem_wen_o,
//   mem_wdata_o, mem_be_o, mem_rdata_i   SRAM bank side (read data one cycle after select)

// Purpose: small generic FIFO, circular buffer with an occupancy counter.
// Latency: pushed data is visible at the head on the following cycle.
// Backpressure: caller must not push while full unless it pops in the same cycle.
module tcdm_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [Width-1:0] head_dat
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;
  logic             full;

  // Pointers wrap explicitly so non-power-of-two depths work; full/empty come from count_q.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_vld = (count_q != '0);
  assign full     = (count_q == CntW'(Depth));
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push_vld;
  assign do_pop   = pop_rdy & head_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) (push_vld && full) |-> pop_rdy);

endmodule

module tcdm_bank_adapter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MemAddrBits = 10,
  parameter int unsigned NumMaster   = 16,
  parameter int unsigned RespDepth   = 2,
  localparam int unsigned IniAddWidth = $clog2(NumMaster),
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [MemAddrBits-1:0] add_i,
  input  logic                   wen_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [BeWidth-1:0]     be_i,
  input  logic [IniAddWidth-1:0] ini_add_i,
  output logic                   vld_o,
  input  logic                   rdy_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IniAddWidth-1:0] ini_add_o,
  output logic                   mem_req_o,
  output logic [MemAddrBits-1:0] mem_add_o,
  output logic                   mem_wen_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [BeWidth-1:0]     mem_be_o,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned CntW = $clog2(RespDepth + 1);

  typedef struct packed {
    logic [IniAddWidth-1:0] id;
    logic [DataWidth-1:0]   dat;
  } resp_t;

  logic [CntW-1:0]        credit_q;
  logic [CntW-1:0]        credit_d;
  logic                   rd_grant;
  logic                   rsp_acc;
  logic                   inflight_q;
  logic [IniAddWidth-1:0] inflight_id_q;
  logic                   fifo_push;
  logic                   fifo_head_vld;
  resp_t                  fifo_head;
  resp_t                  bypass_rsp;

  // Grant never looks at rdy_i: a read is only accepted if a FIFO slot is
  // already reserved for it, so the response can always be parked.
  assign gnt_o    = req_i & (wen_i | (credit_q != '0)) & ~rst_i;
  assign rd_grant = gnt_o & ~wen_i;

  assign mem_req_o   = req_i & gnt_o;
  assign mem_add_o   = add_i;
  assign mem_wen_o   = wen_i;
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  // The SRAM answer for last cycle's read, tagged with the captured initiator id.
  assign bypass_rsp.id  = inflight_id_q;
  assign bypass_rsp.dat = mem_rdata_i;

  // Queued responses always go first so a fresh read never overtakes them.
  assign vld_o     = fifo_head_vld | inflight_q;
  assign rdata_o   = fifo_head_vld ? fifo_head.dat : bypass_rsp.dat;
  assign ini_add_o = fifo_head_vld ? fifo_head.id  : bypass_rsp.id;
  assign rsp_acc   = vld_o & rdy_i;

  // SRAM data is only valid for one cycle, so a bypass response that is not
  // taken immediately (or is queued behind older ones) is captured; this keeps
  // vld_o/rdata_o stable while the consumer stalls.
  assign fifo_push = inflight_q & (fifo_head_vld | ~rdy_i);

  tcdm_fifo #(
    .Width ($bits(resp_t)),
    .Depth (RespDepth)
  ) i_resp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (fifo_push),
    .push_dat (bypass_rsp),
    .pop_rdy  (rdy_i),
    .head_vld (fifo_head_vld),
    .head_dat (fifo_head)
  );

  // credit = free FIFO slots minus reads whose data is still on its way.
  always_comb begin
    credit_d = credit_q;
    if (rsp_acc && !rd_grant) begin
      credit_d = credit_q + CntW'(1);
    end else if (!rsp_acc && rd_grant) begin
      credit_d = credit_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q      <= CntW'(RespDepth);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      credit_q   <= credit_d;
      inflight_q <= rd_grant;
      if (rd_grant) inflight_id_q <= ini_add_i;
    end
  end

  a_credit_max: assert property (@(posedge clk_i) disable iff (rst_i)
    credit_q <= CntW'(RespDepth));
  a_credit_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_grant && !rsp_acc && credit_q == '0));
  a_credit_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_acc && !rd_grant && credit_q == CntW'(RespDepth)));

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
module tb_tcdm_bank_adapter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int IW = 4;
  localparam int RD = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] dat;
  } exp_rsp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] add_i;
  logic          wen_i;
  logic [DW-1:0] wdata_i;
  logic [3:0]    be_i;
  logic [IW-1:0] ini_add_i;
  logic          vld_o;
  logic          rdy_i;
  logic [DW-1:0] rdata_o;
  logic [IW-1:0] ini_add_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_add_o;
  logic          mem_wen_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] sram   [1024];
  logic [DW-1:0] shadow [1024];

  always #5 clk_i = ~clk_i;

  tcdm_bank_adapter #(
    .DataWidth   (DW),
    .MemAddrBits (AW),
    .NumMaster   (16),
    .RespDepth   (RD)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .ini_add_i   (ini_add_i),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .rdata_o     (rdata_o),
    .ini_add_o   (ini_add_o),
    .mem_req_o   (mem_req_o),
    .mem_add_o   (mem_add_o),
    .mem_wen_o   (mem_wen_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Behavioural SRAM bank: read data appears the cycle after the select.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_wen_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_add_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata_i <= sram[mem_add_o];
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic wen, input logic [AW-1:0] add,
                       input logic [IW-1:0] id, input logic rdy);
    req_i = req; wen_i = wen; add_i = add; ini_add_i = id; rdy_i = rdy;
    wdata_i = '0; be_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 1'b1, 10'h001, 4'd0, 1'b1);
    #3;
    n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld_o); end
    cyc(); cyc();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_vld: got %b want 0", vld_o); end
    cyc();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 10'h005, 4'd3, 1'b1);
    #1;
    n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", gnt_o); end
    n_checks++; if ({mem_req_o, mem_wen_o, mem_add_o} !== {1'b1, 1'b0, 10'h005}) begin
      n_fail++; $display("FAIL single_mem_port: got req=%b wen=%b add=%h", mem_req_o, mem_wen_o, mem_add_o); end
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL single_vld_T: got %b want 0", vld_o); end
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0005, 4'd3}) begin
      n_fail++; $display("FAIL single_rsp: got vld=%b data=%h id=%0d want 1 cafe0005 3", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL single_vld_T2: got %b want 0", vld_o); end
  endtask

  task automatic test_write();
    drive(1'b1, 1'b1, 10'h010, 4'd2, 1'b1);
    wdata_i = 32'hDEADBEEF; be_i = 4'b0011;
    #1;
    n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL write_gnt: got %b want 1", gnt_o); end
    n_checks++; if ({mem_req_o, mem_wen_o, mem_be_o, mem_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL write_mem_port: got req=%b wen=%b be=%b wdata=%h", mem_req_o, mem_wen_o, mem_be_o, mem_wdata_o); end
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL write_no_rsp: got vld %b want 0", vld_o); end
    cyc();
    drive(1'b1, 1'b0, 10'h010, 4'd7, 1'b1);
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFEBEEF, 4'd7}) begin
      n_fail++; $display("FAIL write_readback: got vld=%b data=%h id=%0d want 1 cafebeef 7", vld_o, rdata_o, ini_add_o); end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_g = 4'b0011;
    logic [3:0] exp_v = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 10'h020 + 10'(k), 4'(k), 1'b0);
      #1;
      n_checks++; if (gnt_o !== exp_g[k]) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b want %b", k, gnt_o, exp_g[k]); end
      n_checks++; if (vld_o !== exp_v[k]) begin n_fail++; $display("FAIL bp_vld[%0d]: got %b want %b", k, vld_o, exp_v[k]); end
      if (k > 0) begin
        n_checks++; if ({rdata_o, ini_add_o} !== {32'hCAFE0020, 4'd0}) begin
          n_fail++; $display("FAIL bp_stable[%0d]: got %h/%0d want cafe0020/0", k, rdata_o, ini_add_o); end
      end
      cyc();
    end
    drive(1'b1, 1'b1, 10'h3FF, 4'd9, 1'b0);
    #1;
    n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL bp_write_gnt: got %b want 1", gnt_o); end
    n_checks++; if ({vld_o, rdata_o} !== {1'b1, 32'hCAFE0020}) begin
      n_fail++; $display("FAIL bp_write_stall: got vld=%b data=%h", vld_o, rdata_o); end
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0020, 4'd0}) begin
      n_fail++; $display("FAIL bp_drain0: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0021, 4'd1}) begin
      n_fail++; $display("FAIL bp_drain1: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got vld %b want 0", vld_o); end
  endtask

  task automatic test_full_pop_grant();
    // Credits restored: two reads granted again under stall, third refused.
    logic [2:0] exp_g = 3'b011;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 10'h030 + 10'(k), 4'(5 + k), 1'b0);
      #1;
      n_checks++; if (gnt_o !== exp_g[k]) begin n_fail++; $display("FAIL full_fill_gnt[%0d]: got %b want %b", k, gnt_o, exp_g[k]); end
      cyc();
    end
    // FIFO full, consumer ready: pop happens but credit is still zero this cycle.
    drive(1'b1, 1'b0, 10'h033, 4'd8, 1'b1);
    #1;
    n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL full_gnt_c3: got %b want 0", gnt_o); end
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0030, 4'd5}) begin
      n_fail++; $display("FAIL full_head_c3: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_gnt_c4: got %b want 1", gnt_o); end
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0031, 4'd6}) begin
      n_fail++; $display("FAIL full_head_c4: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    drive(1'b1, 1'b0, 10'h034, 4'd9, 1'b1);
    #1;
    n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_gnt_c5: got %b want 1", gnt_o); end
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0033, 4'd8}) begin
      n_fail++; $display("FAIL full_rsp_c5: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0034, 4'd9}) begin
      n_fail++; $display("FAIL full_rsp_c6: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL full_drained: got vld %b want 0", vld_o); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_g = 3'b011;
    drive(1'b1, 1'b0, 10'h040, 4'd10, 1'b0); cyc();
    drive(1'b1, 1'b0, 10'h041, 4'd11, 1'b0); cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b0); cyc();
    #1;
    n_checks++; if (vld_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued: got vld %b want 1", vld_o); end
    drive(1'b1, 1'b0, 10'h045, 4'd1, 1'b0);
    rst_i = 1'b1;
    #1;
    n_checks++; if ({vld_o, gnt_o, mem_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_outputs: got vld=%b gnt=%b mem_req=%b want 000", vld_o, gnt_o, mem_req_o); end
    cyc();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d]: got vld %b want 0", k, vld_o); end
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 10'h042 + 10'(k), 4'(12 + k), 1'b0);
      #1;
      n_checks++; if (gnt_o !== exp_g[k]) begin n_fail++; $display("FAIL rstmid_credit[%0d]: got %b want %b", k, gnt_o, exp_g[k]); end
      cyc();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0042, 4'd12}) begin
      n_fail++; $display("FAIL rstmid_rsp0: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0043, 4'd13}) begin
      n_fail++; $display("FAIL rstmid_rsp1: got vld=%b %h/%0d", vld_o, rdata_o, ini_add_o); end
    cyc();
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_drained: got vld %b want 0", vld_o); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 10'h050 + 10'(k), 4'(k), 1'b1);
      else       drive(1'b0, 1'b0, '0, '0, 1'b1);
      #1;
      if (k < 8) begin
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, gnt_o); end
      end
      if (k > 0) begin
        n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, 32'hCAFE0050 + 32'(k - 1), 4'(k - 1)}) begin
          n_fail++; $display("FAIL b2b_rsp[%0d]: got vld=%b %h/%0d", k, vld_o, rdata_o, ini_add_o); end
      end
      cyc();
    end
    #1;
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got vld %b want 0", vld_o); end
  endtask

  task automatic test_random();
    exp_rsp_t      q[$];
    exp_rsp_t      e;
    logic          exp_g;
    logic          exp_v;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [IW-1:0] prev_id = '0;
    for (int c = 0; c < 10000; c++) begin
      req_i     = ($urandom_range(0, 3) != 0);
      wen_i     = ($urandom_range(0, 2) == 0);
      add_i     = 10'h100 + 10'($urandom_range(0, 15));
      wdata_i   = $urandom;
      be_i      = 4'($urandom_range(0, 15));
      ini_add_i = 4'($urandom_range(0, 15));
      rdy_i     = 1'($urandom_range(0, 1));
      if (c >= 9996) begin req_i = 1'b0; rdy_i = 1'b1; end
      #1;
      exp_g = req_i && (wen_i || (RD - q.size()) > 0);
      exp_v = (q.size() > 0);
      n_checks++; if (gnt_o !== exp_g) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt_o, exp_g); end
      n_checks++; if (vld_o !== exp_v) begin n_fail++; $display("FAIL rnd_vld@%0d: got %b want %b", c, vld_o, exp_v); end
      if (exp_v) begin
        e = q[0];
        n_checks++; if ({rdata_o, ini_add_o} !== {e.dat, e.id}) begin
          n_fail++; $display("FAIL rnd_rsp@%0d: got %h/%0d want %h/%0d", c, rdata_o, ini_add_o, e.dat, e.id); end
      end
      if (prev_stall) begin
        n_checks++; if ({vld_o, rdata_o, ini_add_o} !== {1'b1, prev_dat, prev_id}) begin
          n_fail++; $display("FAIL rnd_stable@%0d: got vld=%b %h/%0d want 1 %h/%0d", c, vld_o, rdata_o, ini_add_o, prev_dat, prev_id); end
      end
      prev_stall = exp_v && !rdy_i;
      prev_dat   = rdata_o;
      prev_id    = ini_add_o;
      if (exp_v && rdy_i) void'(q.pop_front());
      if (exp_g && !wen_i) begin
        e.id = ini_add_i; e.dat = shadow[add_i];
        q.push_back(e);
      end
      if (exp_g && wen_i) begin
        for (int b = 0; b < 4; b++)
          if (be_i[b]) shadow[add_i][b*8 +: 8] = wdata_i[b*8 +: 8];
      end
      cyc();
    end
    #1;
    n_checks++; if (vld_o !== 1'b0 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd_end: vld=%b outstanding=%0d want 0/0", vld_o, q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 32'hCAFE0000 | 32'(i);
      shadow[i] = 32'hCAFE0000 | 32'(i);
    end
    mem_rdata_i = '0;
    test_reset();
    test_single_read();
    test_write();
    test_backpressure();
    test_full_pop_grant();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
